// File: rtl/pong_match_sequencer.sv
// Pong game-flow controller: sequences attract, serve, rally, point and game-over
// phases, keeps both scores and gates the ball engine.
module pong_match_sequencer #(
  parameter int unsigned WIN_SCORE          = 7,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned SCORE_WIDTH        = 4
) (
  input  logic                   PIXEL_CLOCK,
  input  logic                   RESET,
  input  logic                   FRAME_TICK,
  input  logic                   START_N,
  input  logic                   GOAL_P1,
  input  logic                   GOAL_P2,
  output logic                   BALL_RESET,
  output logic                   BALL_ENABLE,
  output logic                   SERVE_DIR,
  output logic [SCORE_WIDTH-1:0] P1_SCORE,
  output logic [SCORE_WIDTH-1:0] P2_SCORE,
  output logic                   GAME_OVER,
  output logic                   WINNER,
  output logic [2:0]             STATE
);

  localparam int unsigned CNT_W = (SERVE_DELAY_FRAMES < 2) ? 1 : $clog2(SERVE_DELAY_FRAMES);
  localparam logic [CNT_W-1:0]       SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN        = SCORE_WIDTH'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    SCORED = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic             start_meta;
  logic             start_sync;
  logic             start_prev;
  logic             press;

  // Falling edge of the synchronised button; flops idle high (released).
  assign press = start_prev & ~start_sync;
  assign STATE = state;

  always_ff @(posedge PIXEL_CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      serve_cnt   <= '0;
      P1_SCORE    <= '0;
      P2_SCORE    <= '0;
      BALL_ENABLE <= 1'b0;
      BALL_RESET  <= 1'b0;
      SERVE_DIR   <= 1'b0;
      GAME_OVER   <= 1'b0;
      WINNER      <= 1'b0;
      start_meta  <= 1'b1;
      start_sync  <= 1'b1;
      start_prev  <= 1'b1;
    end else begin
      start_meta <= START_N;
      start_sync <= start_meta;
      start_prev <= start_sync;
      BALL_RESET <= 1'b0;

      case (state)
        IDLE, OVER: begin
          BALL_ENABLE <= 1'b0;
          if (press) begin
            P1_SCORE   <= '0;
            P2_SCORE   <= '0;
            SERVE_DIR  <= 1'b0;
            GAME_OVER  <= 1'b0;
            serve_cnt  <= '0;
            BALL_RESET <= 1'b1;
            state      <= SERVE;
          end
        end

        SERVE: begin
          BALL_ENABLE <= 1'b0;
          if (FRAME_TICK) begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt   <= '0;
              BALL_ENABLE <= 1'b1;
              state       <= PLAY;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end

        PLAY: begin
          BALL_ENABLE <= 1'b1;
          // GOAL_P1 wins a same-cycle tie with GOAL_P2.
          if (GOAL_P1) begin
            if (P1_SCORE < WIN) P1_SCORE <= P1_SCORE + 1'b1;
            SERVE_DIR   <= 1'b0;
            BALL_ENABLE <= 1'b0;
            BALL_RESET  <= 1'b1;
            state       <= SCORED;
          end else if (GOAL_P2) begin
            if (P2_SCORE < WIN) P2_SCORE <= P2_SCORE + 1'b1;
            SERVE_DIR   <= 1'b1;
            BALL_ENABLE <= 1'b0;
            BALL_RESET  <= 1'b1;
            state       <= SCORED;
          end
        end

        SCORED: begin
          BALL_ENABLE <= 1'b0;
          if (P1_SCORE == WIN) begin
            WINNER    <= 1'b0;
            GAME_OVER <= 1'b1;
            state     <= OVER;
          end else if (P2_SCORE == WIN) begin
            WINNER    <= 1'b1;
            GAME_OVER <= 1'b1;
            state     <= OVER;
          end else begin
            serve_cnt <= '0;
            state     <= SERVE;
          end
        end

        default: begin
          P1_SCORE    <= '0;
          P2_SCORE    <= '0;
          serve_cnt   <= '0;
          BALL_ENABLE <= 1'b0;
          GAME_OVER   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
Game-flow controller for the Pong datapath. It sequences the ball/paddle engine through attract, serve, rally, point-scored and game-over phases. It keeps both players' scores and gates ball motion, ball recentering and serve direction for the ball engine. It runs on the pixel clock alongside the raster/collision logic and consumes that logic's goal pulses.

Parameters:
WIN_SCORE, 7, score that ends the match; must be at most 2^SCORE_WIDTH-1
SERVE_DELAY_FRAMES, 60, frames the ball is held at centre before each serve; must be at least 1
SCORE_WIDTH, 4, width of each score counter

Ports:
PIXEL_CLOCK  in  1  block clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
FRAME_TICK  in  1  one-cycle pulse per video frame (start of vertical blank)
START_N  in  1  start button, active-low, asynchronous to PIXEL_CLOCK
GOAL_P1  in  1  one-cycle pulse: ball left the field on the right, so P1 scores
GOAL_P2  in  1  one-cycle pulse: ball left the field on the left, so P2 scores
BALL_RESET  out  1  one-cycle pulse: ball engine recentres the ball
BALL_ENABLE  out  1  1 = ball engine may move the ball
SERVE_DIR  out  1  0 = serve toward +X (P2 side), 1 = toward -X (P1 side)
P1_SCORE  out  SCORE_WIDTH  player 1 score
P2_SCORE  out  SCORE_WIDTH  player 2 score
GAME_OVER  out  1  high while in OVER
WINNER  out  1  0 = P1 won, 1 = P2 won; valid while GAME_OVER is high
STATE  out  3  current state encoding, for debug and the bench

Behaviour:
- States and encodings: IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4. All outputs are registered.
- RESET, from any state and mid-rally:
  - next edge: STATE=IDLE; scores=0; BALL_ENABLE=0; BALL_RESET=0; SERVE_DIR=0; GAME_OVER=0; WINNER=0; serve counter=0.
  - the synchronizer flops and the edge flop load 1 (button released).
- START_N passes through a 2-flop synchronizer, then a falling-edge detector. A press is valid for exactly one cycle.
  - If START_N is first sampled low at edge k, STATE shows SERVE after edge k+2.
  - Holding the button produces no further presses.
- IDLE: BALL_ENABLE=0. GOAL_* ignored. On a press:
  - scores cleared, SERVE_DIR=0, GAME_OVER=0, counter=0
  - BALL_RESET pulses for one cycle; go to SERVE.
- SERVE: BALL_ENABLE=0. GOAL_* and presses ignored.
  - Each FRAME_TICK increments the counter.
  - On a FRAME_TICK with counter==SERVE_DELAY_FRAMES-1: counter=0, go to PLAY, BALL_ENABLE=1 from the same edge.
  - So PLAY starts on exactly the SERVE_DELAY_FRAMES-th tick after entry. A tick in the entry cycle itself is not counted.
- PLAY: BALL_ENABLE=1. Presses ignored.
  - GOAL_P1: P1_SCORE+1, SERVE_DIR=0.
  - GOAL_P2: P2_SCORE+1, SERVE_DIR=1.
  - Both in the same cycle: only GOAL_P1 is taken.
  - On either goal, on the same edge: BALL_ENABLE=0, BALL_RESET pulses, go to SCORED.
- SCORED (exactly one cycle): BALL_ENABLE=0. GOAL_* ignored.
  - If P1_SCORE==WIN_SCORE: go to OVER, WINNER=0.
  - Else if P2_SCORE==WIN_SCORE: go to OVER, WINNER=1.
  - Else: counter=0, go to SERVE.
- OVER: GAME_OVER=1, BALL_ENABLE=0. Scores and WINNER are held. A press behaves exactly as the IDLE press, including GAME_OVER=0.
- Scores never exceed WIN_SCORE, and they never wrap.
- Unused encodings 5-7 go to IDLE on the next edge with scores cleared.
- BALL_RESET is never high for two consecutive cycles.

Test Plan:
- Reset then start: RESET high 2 cycles, then START_N low at edge k → STATE=1 after k+2. BALL_RESET high for exactly that cycle. Scores 0. BALL_ENABLE=0.
- Serve delay (SERVE_DELAY_FRAMES=3): 3 FRAME_TICKs in SERVE → STATE=2 and BALL_ENABLE=1 on the 3rd tick edge. After only 2 ticks, still SERVE. GOAL_P1 pulsed during SERVE → P1_SCORE stays 0.
- Point flow: GOAL_P2 in PLAY → P2_SCORE=1, SERVE_DIR=1, BALL_ENABLE=0, BALL_RESET pulse, then SCORED for 1 cycle, then SERVE. Simultaneous GOAL_P1 and GOAL_P2 → P1_SCORE+1 only, SERVE_DIR=0.
- Match end (WIN_SCORE=2): two GOAL_P1 rallies → STATE=4, GAME_OVER=1, WINNER=0, P1_SCORE=2. Further goals leave the scores unchanged. A press → scores 0, STATE=1.
- Reset mid-rally: RESET in PLAY with scores 3:2 → next edge STATE=0, scores 0, BALL_ENABLE=0.
- Button hold and bounce: START_N held low for 1000 cycles in IDLE → exactly one BALL_RESET pulse. A press during PLAY → no state change.
